mem_access_ctrl: RTL and testbench

- Initiator side of the data-memory interface: accepts load/store requests from the CPU datapath and drives the memory's mem_read/mem_write/address/write_data pins. It also captures read_data and returns a one-cycle response.
- Sits between the execute/memory stage and data_memory.
- Turns the memory's level-driven combinational-read interface into a clocked valid/ready request/response handshake with a configurable read latency.

---
 rtl/mem_access_ctrl_if.sv | 38 +++
 rtl/mem_access_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response handshake plus data-memory pins.
// slave = controller side, master = requester and memory side.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic              req_signed;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic [31:0]       read_data;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_size, req_signed,
    output read_data,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_read, mem_write, address,
    input  write_data
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_size, req_signed,
    input  read_data,
    output req_ready, resp_valid, resp_rdata,
    output mem_read, mem_write, address,
    output write_data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: valid/ready front end for a combinational-read memory.
// Define LS_SUBWORD_EN for byte/half loads and read-modify-write stores.
module mem_access_ctrl #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);
  localparam int CW =
    (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE, RD, WR, RESP
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              req_ready_q, req_ready_n;
  logic              resp_valid_q, resp_valid_n;
  logic [31:0]       resp_rdata_q, resp_rdata_n;
  logic              mem_read_q, mem_read_n;
  logic              mem_write_q, mem_write_n;
  logic [ADDR_W-1:0] address_q, address_n;
  logic [31:0]       write_data_q, write_data_n;

  logic              sub_req;
  logic              sub_rmw;
  logic [31:0]       ld_val;
  logic [31:0]       st_val;

`ifdef LS_SUBWORD_EN
  logic              lat_write;
  logic              lat_signed;
  logic [1:0]        lat_lane;
  logic [1:0]        lat_size;
  logic [31:0]       lat_wdata;

  assign sub_req = bus.req_write && !bus.req_size[1];
  // in RD, a latched store can only be a sub-word RMW
  assign sub_rmw = lat_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write  <= 1'b0;
      lat_signed <= 1'b0;
      lat_lane   <= 2'b00;
      lat_size   <= 2'b00;
      lat_wdata  <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      lat_write  <= bus.req_write;
      lat_signed <= bus.req_signed;
      lat_lane   <= bus.req_addr[1:0];
      lat_size   <= bus.req_size;
      lat_wdata  <= bus.req_wdata;
    end
  end

  always_comb begin
    ld_val = bus.read_data;
    st_val = bus.read_data;
    unique case (1'b1)
      (lat_size == 2'b00): begin
        ld_val = {24'd0,
          bus.read_data[{lat_lane, 3'b000} +: 8]};
        if (lat_signed)
          ld_val[31:8] = {24{ld_val[7]}};
        st_val[{lat_lane, 3'b000} +: 8] =
          lat_wdata[7:0];
      end
      (lat_size == 2'b01): begin
        ld_val = {16'd0,
          bus.read_data[{lat_lane[1], 4'b0000} +: 16]};
        if (lat_signed)
          ld_val[31:16] = {16{ld_val[15]}};
        st_val[{lat_lane[1], 4'b0000} +: 16] =
          lat_wdata[15:0];
      end
      default: ;
    endcase
  end
`else
  logic unused_sub;

  assign unused_sub = ^{bus.req_size,
    bus.req_signed, bus.req_addr[1:0]};
  assign sub_req = 1'b0;
  assign sub_rmw = 1'b0;
  assign ld_val  = bus.read_data;
  assign st_val  = bus.read_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      req_ready_q  <= req_ready_n;
      resp_valid_q <= resp_valid_n;
      resp_rdata_q <= resp_rdata_n;
      mem_read_q   <= mem_read_n;
      mem_write_q  <= mem_write_n;
      address_q    <= address_n;
      write_data_q <= write_data_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: if (bus.req_valid) begin
        cnt_n   = CNT_INIT;
        state_n = (bus.req_write && !sub_req) ?
                  WR : RD;
      end
      RD: begin
        if (cnt != '0)
          cnt_n = cnt - CW'(1);
        else
          state_n = sub_rmw ? WR : RESP;
      end
      WR:      state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // next values for the registered outputs
  always_comb begin
    req_ready_n  = req_ready_q;
    resp_valid_n = 1'b0;
    resp_rdata_n = resp_rdata_q;
    mem_read_n   = mem_read_q;
    mem_write_n  = 1'b0;
    address_n    = address_q;
    write_data_n = write_data_q;
    unique case (state)
      IDLE: if (bus.req_valid) begin
        req_ready_n = 1'b0;
        address_n   = bus.req_addr >> 2;
        if (bus.req_write && !sub_req) begin
          mem_write_n  = 1'b1;
          write_data_n = bus.req_wdata;
        end else begin
          mem_read_n = 1'b1;
        end
      end
      RD: if (cnt == '0) begin
        mem_read_n = 1'b0;
        if (sub_rmw) begin
          mem_write_n  = 1'b1;
          write_data_n = st_val;
        end else begin
          resp_rdata_n = ld_val;
          resp_valid_n = 1'b1;
        end
      end
      WR:      resp_valid_n = 1'b1;
      RESP:    req_ready_n  = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.address    = address_q;
  assign bus.write_data = write_data_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: random loads/stores against a transaction-level
// model of a 16-word aliased memory; covers latency, reset and lanes.
module tb_mem_access_ctrl;
  localparam int LAT = 3;
  localparam int AW  = 32;
`ifdef LS_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(AW)) bus ();

  mem_access_ctrl #(
    .MEM_LATENCY(LAT),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] prev_rdata;
  logic        bd_we;
  logic [3:0]  bd_idx;
  logic [31:0] bd_val;

  assign bus.read_data = mem[bus.address[3:0]];

  always @(posedge clk) begin
    if (bd_we)
      mem[bd_idx] <= bd_val;
    else if (bus.mem_write)
      mem[bus.address[3:0]] <= bus.write_data;
  end

  int checks = 0;
  int errors = 0;
  int excl_bad = 0;

  always @(negedge clk)
    if (bus.mem_read && bus.mem_write)
      excl_bad++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int idx,
                      input logic [31:0] val);
    bd_we  = 1'b1;
    bd_idx = idx[3:0];
    bd_val = val;
    tick;
    bd_we  = 1'b0;
    ref_mem[idx] = val;
  endtask

  function automatic logic [31:0] model_load(
    input logic [31:0] word,
    input logic [31:0] addr,
    input logic [1:0]  size,
    input logic        sgn);
    int unsigned v;
    int unsigned sh;
    if (!SUB || size[1])
      return word;
    if (size == 2'b00) begin
      sh = 8 * addr[1:0];
      v  = (word >> sh) % 256;
      if (sgn && v >= 128)
        v = v + 32'hFFFF_FF00;
    end else begin
      sh = 16 * addr[1];
      v  = (word >> sh) % 65536;
      if (sgn && v >= 32768)
        v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(
    input logic [31:0] word,
    input logic [31:0] addr,
    input logic [1:0]  size,
    input logic [31:0] wd);
    int unsigned sh;
    int unsigned mask;
    if (!SUB || size[1])
      return wd;
    if (size == 2'b00) begin
      sh   = 8 * addr[1:0];
      mask = 255 << sh;
      return (word & ~mask) |
             ((wd % 256) << sh);
    end
    sh   = 16 * addr[1];
    mask = 65535 << sh;
    return (word & ~mask) |
           ((wd % 65536) << sh);
  endfunction

  task automatic do_req(input logic        wr,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [1:0]  sz,
                        input logic        sg,
                        input bit          hold);
    int idx;
    bit sub;
    int exp_lat, exp_rd, exp_wr;
    logic [31:0] exp_wd, exp_rdata, wd_seen;
    int n, cyc, rd_n, wr_n, rl_n, addr_bad;
    bit got;
    idx = int'((addr >> 2) & 32'd15);
    sub = SUB && wr && !sz[1];
    exp_lat = !wr ? LAT + 1 : (sub ? LAT + 2 : 2);
    exp_rd  = (!wr || sub) ? LAT : 0;
    exp_wr  = wr ? 1 : 0;
    exp_wd  = model_store(ref_mem[idx], addr, sz, wd);
    exp_rdata = wr ? prev_rdata :
      model_load(ref_mem[idx], addr, sz, sg);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check("ready_wait", bus.req_ready, 1);
    bus.req_write  = wr;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_valid  = 1'b1;
    tick;
    if (!hold)
      bus.req_valid = 1'b0;
    cyc = 1;
    rd_n = 0;
    wr_n = 0;
    rl_n = 0;
    addr_bad = 0;
    wd_seen = '0;
    got = 1'b0;
    while (!got && cyc <= 30) begin
      if (bus.mem_read)
        rd_n++;
      if (bus.mem_write) begin
        wr_n++;
        wd_seen = bus.write_data;
      end
      if ((bus.mem_read || bus.mem_write) &&
          bus.address !== (addr >> 2))
        addr_bad++;
      if (!bus.req_ready)
        rl_n++;
      if (bus.resp_valid) begin
        got = 1'b1;
      end else begin
        tick;
        cyc++;
      end
    end
    bus.req_valid = 1'b0;
    check("resp_lat", cyc, exp_lat);
    check("rd_cycles", rd_n, exp_rd);
    check("wr_cycles", wr_n, exp_wr);
    check("ready_low", rl_n, exp_lat);
    check("addr", addr_bad, 0);
    if (wr)
      check("wdata", wd_seen, exp_wd);
    check("rdata", bus.resp_rdata, exp_rdata);
    tick;
    check("resp_pulse", bus.resp_valid, 0);
    check("ready_back", bus.req_ready, 1);
    if (wr)
      ref_mem[idx] = exp_wd;
    else
      prev_rdata = exp_rdata;
  endtask

  initial begin
    int rv_seen;
    rst            = 1'b1;
    bd_we          = 1'b0;
    bd_idx         = '0;
    bd_val         = '0;
    prev_rdata     = '0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    repeat (2) tick;
    check("rst_ready", bus.req_ready, 1);
    check("rst_resp", bus.resp_valid, 0);
    check("rst_rdata", bus.resp_rdata, 0);
    check("rst_mrd", bus.mem_read, 0);
    check("rst_mwr", bus.mem_write, 0);
    check("rst_addr", bus.address, 0);
    check("rst_wdata", bus.write_data, 0);
    for (int i = 0; i < 16; i++)
      poke(i, $urandom);
    rst = 1'b0;
    tick;

    poke(5, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h14, '0, 2'b10, 1'b0, 1'b0);
    check("ld_w5", bus.resp_rdata, 32'hDEAD_BEEF);
    do_req(1'b1, 32'h20, 32'h1234_5678,
           2'b10, 1'b0, 1'b0);
    check("st_w8", mem[8], 32'h1234_5678);
    do_req(1'b0, 32'h20, '0, 2'b10, 1'b0, 1'b1);
    check("ld_w8", bus.resp_rdata, 32'h1234_5678);

    bus.req_write = 1'b0;
    bus.req_addr  = 32'h14;
    bus.req_size  = 2'b10;
    bus.req_valid = 1'b1;
    tick;
    bus.req_valid = 1'b0;
    check("mid_rd", bus.mem_read, 1);
    tick;
    #2 rst = 1'b1;
    #1;
    check("arst_mrd", bus.mem_read, 0);
    check("arst_resp", bus.resp_valid, 0);
    rv_seen = 0;
    repeat (2) begin
      tick;
      if (bus.resp_valid)
        rv_seen++;
    end
    rst = 1'b0;
    repeat (3) begin
      tick;
      if (bus.resp_valid)
        rv_seen++;
    end
    check("arst_noresp", rv_seen, 0);
    check("arst_ready", bus.req_ready, 1);
    check("arst_rdata", bus.resp_rdata, 0);
    prev_rdata = '0;

`ifdef LS_SUBWORD_EN
    poke(0, 32'h80FF_7F01);
    do_req(1'b0, 32'h2, '0, 2'b00, 1'b1, 1'b0);
    check("lb_2", bus.resp_rdata, 32'hFFFF_FFFF);
    do_req(1'b0, 32'h3, '0, 2'b00, 1'b0, 1'b0);
    check("lbu_3", bus.resp_rdata, 32'h0000_0080);
    do_req(1'b0, 32'h2, '0, 2'b01, 1'b1, 1'b0);
    check("lh_2", bus.resp_rdata, 32'hFFFF_80FF);
    poke(0, 32'h1122_3344);
    do_req(1'b1, 32'h1, 32'hAA, 2'b00, 1'b0, 1'b0);
    check("sb_1", mem[0], 32'h1122_AA44);
`endif

    for (int t = 0; t < 80; t++) begin
      do_req(1'($urandom % 2), $urandom, $urandom,
             2'($urandom % 4), 1'($urandom % 2),
             bit'($urandom % 2));
    end

    for (int i = 0; i < 16; i++)
      check("mem_final", mem[i], ref_mem[i]);
    check("rd_wr_excl", excl_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
